// File: rtl/cap_timing_gen.sv
// cap_timing_gen: capture-side input pipeline, active-area coordinates, frame-change strobe and h/v total measurement.
// Field-ID / interlace detection is compiled in only when CAP_FID_DETECT_EN is defined.
module cap_timing_gen #(
  parameter int FC_LINES = 2
) (
  input  logic        PCLK_CAP_i,
  input  logic        reset_n,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  input  logic        DE_i,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o,
  output logic        frame_change_o,
  output logic        FID_o,
  output logic        interlaced_o,
  output logic [11:0] h_total_o,
  output logic [10:0] v_total_o
);

  logic [7:0]  r_r_s1, r_g_s1, r_b_s1;
  logic        r_hs_s1, r_vs_s1, r_de_s1;
  logic        r_hs_s2, r_vs_s2, r_de_s2;
  logic [11:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [3:0]  r_fc_cnt;
  logic        r_first_line;
  logic        r_h_seen;
  logic        r_v_seen;

  logic        w_hs_edge, w_vs_edge, w_de_rise;
  logic [10:0] w_v_cnt_inc;

  assign w_hs_edge   = ~r_hs_s1 & r_hs_s2;
  assign w_vs_edge   = ~r_vs_s1 & r_vs_s2;
  assign w_de_rise   = r_de_s1 & ~r_de_s2;
  // A coincident HS edge counts toward the field that is closing.
  assign w_v_cnt_inc = (w_hs_edge && r_v_cnt != 11'h7FF) ? r_v_cnt + 11'd1 : r_v_cnt;

  // Sync registers reset to their idle (high) level so no edge is seen on the first clock.
  always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
    if (!reset_n) begin
      r_r_s1  <= 8'd0;
      r_g_s1  <= 8'd0;
      r_b_s1  <= 8'd0;
      r_hs_s1 <= 1'b1;
      r_vs_s1 <= 1'b1;
      r_de_s1 <= 1'b0;
      r_hs_s2 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_de_s2 <= 1'b0;
      R_o     <= 8'd0;
      G_o     <= 8'd0;
      B_o     <= 8'd0;
      HSYNC_o <= 1'b1;
      VSYNC_o <= 1'b1;
      DE_o    <= 1'b0;
    end else begin
      r_r_s1  <= R_i;
      r_g_s1  <= G_i;
      r_b_s1  <= B_i;
      r_hs_s1 <= HSYNC_i;
      r_vs_s1 <= VSYNC_i;
      r_de_s1 <= DE_i;
      r_hs_s2 <= r_hs_s1;
      r_vs_s2 <= r_vs_s1;
      r_de_s2 <= r_de_s1;
      R_o     <= r_r_s1;
      G_o     <= r_g_s1;
      B_o     <= r_b_s1;
      HSYNC_o <= r_hs_s1;
      VSYNC_o <= r_vs_s1;
      DE_o    <= r_de_s1;
    end
  end

  always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
    if (!reset_n) begin
      xpos_o       <= 11'd0;
      ypos_o       <= 11'd0;
      r_first_line <= 1'b0;
    end else begin
      if (w_de_rise)
        xpos_o <= 11'd0;
      else if (r_de_s1 && xpos_o != 11'h7FF)
        xpos_o <= xpos_o + 11'd1;
      if (w_de_rise) begin
        if (r_first_line) begin
          ypos_o       <= 11'd0;
          r_first_line <= 1'b0;
        end else if (ypos_o != 11'h7FF) begin
          ypos_o <= ypos_o + 11'd1;
        end
      end
      if (w_vs_edge)
        r_first_line <= 1'b1;
    end
  end

  // Totals are only published once a full line/field has been observed since reset.
  always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt   <= 12'd0;
      r_v_cnt   <= 11'd0;
      r_h_seen  <= 1'b0;
      r_v_seen  <= 1'b0;
      h_total_o <= 12'd0;
      v_total_o <= 11'd0;
    end else begin
      if (w_hs_edge) begin
        if (r_h_seen)
          h_total_o <= (r_h_cnt == 12'hFFF) ? 12'hFFF : r_h_cnt + 12'd1;
        r_h_seen <= 1'b1;
        r_h_cnt  <= 12'd0;
      end else if (r_h_cnt != 12'hFFF) begin
        r_h_cnt <= r_h_cnt + 12'd1;
      end
      if (w_vs_edge) begin
        if (r_v_seen)
          v_total_o <= w_v_cnt_inc;
        r_v_seen <= 1'b1;
        r_v_cnt  <= 11'd0;
      end else begin
        r_v_cnt <= w_v_cnt_inc;
      end
    end
  end

  always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
    if (!reset_n) begin
      frame_change_o <= 1'b0;
      r_fc_cnt       <= 4'd0;
    end else if (w_vs_edge) begin
      frame_change_o <= 1'b1;
      r_fc_cnt       <= 4'(FC_LINES);
    end else if (w_hs_edge && frame_change_o) begin
      if (r_fc_cnt <= 4'd1) begin
        frame_change_o <= 1'b0;
        r_fc_cnt       <= 4'd0;
      end else begin
        r_fc_cnt <= r_fc_cnt - 4'd1;
      end
    end
  end

`ifdef CAP_FID_DETECT_EN
  logic [11:0] w_fid_lo, w_fid_hi;
  logic        w_fid_new;

  // Field 1 when VSYNC falls in the middle half of the line (quarter to three-quarter point).
  assign w_fid_lo  = {2'b00, h_total_o[11:2]};
  assign w_fid_hi  = w_fid_lo + {1'b0, h_total_o[11:1]};
  assign w_fid_new = (r_h_cnt >= w_fid_lo) && (r_h_cnt < w_fid_hi);

  always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
    if (!reset_n) begin
      FID_o        <= 1'b0;
      interlaced_o <= 1'b0;
    end else if (w_vs_edge) begin
      FID_o        <= w_fid_new;
      interlaced_o <= w_fid_new ^ FID_o;
    end
  end
`else
  assign FID_o        = 1'b0;
  assign interlaced_o = 1'b0;
`endif

endmodule

// File: tb/tb_cap_timing_gen.sv
// Self-checking bench for cap_timing_gen: random pixel data, scenario tasks, and a sample-indexed reference model.
module tb_cap_timing_gen;
  localparam int FC_LINES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  R_i, G_i, B_i, R_o, G_o, B_o;
  logic        HSYNC_i, VSYNC_i, DE_i, HSYNC_o, VSYNC_o, DE_o;
  logic [10:0] xpos_o, ypos_o, v_total_o;
  logic        frame_change_o, FID_o, interlaced_o;
  logic [11:0] h_total_o;

  int vectors = 0;
  int miscompares = 0;
  logic vs_lvl;

  always #5 clk = ~clk;

  cap_timing_gen #(.FC_LINES(FC_LINES)) dut (
    .PCLK_CAP_i(clk), .reset_n(rst_n),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
    .xpos_o(xpos_o), .ypos_o(ypos_o),
    .frame_change_o(frame_change_o), .FID_o(FID_o), .interlaced_o(interlaced_o),
    .h_total_o(h_total_o), .v_total_o(v_total_o)
  );

  // Reference model: works on the sequence of applied samples, indexed by m_k.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } samp_t;

  samp_t       m_s1, m_s2;
  int          m_k = 0;
  int          m_last_hs, m_x_start, m_hs_after_vs, m_fc_hs;
  bit          m_hs_seen, m_vs_seen, m_y_armed, m_y_valid;
  logic [7:0]  e_r, e_g, e_b;
  logic        e_hs, e_vs, e_de, e_fc, e_fid, e_il;
  logic [10:0] e_x, e_y, e_vt;
  logic [11:0] e_ht;

  task automatic model_reset();
    m_s1 = {8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0};
    m_s2 = m_s1;
    m_last_hs = m_k;
    m_x_start = m_k;
    m_hs_after_vs = 0;
    m_fc_hs = 0;
    m_hs_seen = 0; m_vs_seen = 0; m_y_armed = 0; m_y_valid = 0;
    {e_r, e_g, e_b} = 24'd0;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
    e_fc = 1'b0; e_fid = 1'b0; e_il = 1'b0;
    e_x = 11'd0; e_y = 11'd0; e_vt = 11'd0; e_ht = 12'd0;
  endtask

  task automatic model_step();
    samp_t s, p;
    bit hs_e, vs_e, de_r;
    int hcnt, tot, ht, d;
    logic nf;
    s = m_s1;
    p = m_s2;
    m_k++;
    hs_e = !s.hs && p.hs;
    vs_e = !s.vs && p.vs;
    de_r = s.de && !p.de;
    {e_r, e_g, e_b, e_hs, e_vs, e_de} = s;
    if (de_r) begin
      m_x_start = m_k;
      e_x = 11'd0;
    end else if (s.de) begin
      d = m_k - m_x_start;
      e_x = 11'((d > 2047) ? 2047 : d);
    end
    if (de_r) begin
      if (m_y_armed) begin
        e_y = 11'd0;
        m_y_armed = 0;
        m_y_valid = 1;
      end else if (e_y != 11'd2047) begin
        e_y = e_y + 11'd1;
      end
    end
    if (vs_e) m_y_armed = 1;
    hcnt = m_k - m_last_hs - 1;
    if (hcnt > 4095) hcnt = 4095;
    ht = int'(e_ht);
    nf = (hcnt >= ht / 4) && (hcnt < ht / 4 + ht / 2);
`ifdef CAP_FID_DETECT_EN
    if (vs_e) begin
      e_il = (nf != e_fid);
      e_fid = nf;
    end
`endif
    if (hs_e) begin
      d = m_k - m_last_hs;
      if (m_hs_seen) e_ht = 12'((d > 4095) ? 4095 : d);
      m_hs_seen = 1;
      m_last_hs = m_k;
    end
    if (vs_e) begin
      tot = m_hs_after_vs + (hs_e ? 1 : 0);
      if (m_vs_seen) e_vt = 11'((tot > 2047) ? 2047 : tot);
      m_vs_seen = 1;
      m_hs_after_vs = 0;
      e_fc = 1'b1;
      m_fc_hs = 0;
    end else if (hs_e) begin
      m_hs_after_vs++;
      if (e_fc) begin
        m_fc_hs++;
        if (m_fc_hs >= FC_LINES) e_fc = 1'b0;
      end
    end
  endtask

  // ypos is only compared once a VSYNC has defined line 0.
  function automatic logic [74:0] exp_vec();
    return {e_r, e_g, e_b, e_hs, e_vs, e_de, e_x, (m_y_valid ? e_y : 11'd0),
            e_fc, e_fid, e_il, e_ht, e_vt};
  endfunction

  function automatic logic [74:0] obs_vec();
    return {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, (m_y_valid ? ypos_o : 11'd0),
            frame_change_o, FID_o, interlaced_o, h_total_o, v_total_o};
  endfunction

  function automatic logic ln_hs(int i, int hs_w);
    return !(i < hs_w);
  endfunction

  function automatic logic ln_de(int i, int off, int len);
    return (i >= off) && (i < off + len);
  endfunction

  // Applies one sample with random pixel data; afterwards the outputs reflect the previous sample.
  task automatic drive(input logic hs, input logic vs, input logic de);
    samp_t n;
    n = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), hs, vs, de};
    {R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i} = n;
    @(posedge clk);
    #1;
    model_step();
    m_s2 = m_s1;
    m_s1 = n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({R_o, G_o, B_o} !== 24'd0) begin
      miscompares++; $display("FAIL reset_rgb: got %h expected 000000", {R_o, G_o, B_o});
    end
    vectors++;
    if ({HSYNC_o, VSYNC_o, DE_o} !== 3'b110) begin
      miscompares++; $display("FAIL reset_syncs: got %b expected 110", {HSYNC_o, VSYNC_o, DE_o});
    end
    vectors++;
    if ({xpos_o, ypos_o} !== 22'd0) begin
      miscompares++; $display("FAIL reset_pos: got x=%0d y=%0d expected 0 0", xpos_o, ypos_o);
    end
    vectors++;
    if ({h_total_o, v_total_o} !== 23'd0) begin
      miscompares++; $display("FAIL reset_totals: got h=%0d v=%0d expected 0 0", h_total_o, v_total_o);
    end
    vectors++;
    if ({frame_change_o, FID_o, interlaced_o} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {frame_change_o, FID_o, interlaced_o});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_progressive();
    int nl;
    nl = $urandom_range(8, 12);
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < nl; l++)
        for (int i = 0; i < 858; i++) begin
          if (l == 0 && i == 0) vs_lvl = 1'b0;
          if (l == 3 && i == 0) vs_lvl = 1'b1;
          drive(ln_hs(i, 62), vs_lvl, (l >= 2) && ln_de(i, 122, 720));
          vectors++;
          if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL prog_cycle f=%0d l=%0d i=%0d: got %h expected %h", f, l, i, obs_vec(), exp_vec());
          end
        end
    vectors++;
    if (h_total_o !== 12'd858) begin
      miscompares++; $display("FAIL prog_h_total: got %0d expected 858", h_total_o);
    end
    vectors++;
    if (v_total_o !== 11'(nl)) begin
      miscompares++; $display("FAIL prog_v_total: got %0d expected %0d", v_total_o, nl);
    end
    vectors++;
    if (ypos_o !== 11'(nl - 3)) begin
      miscompares++; $display("FAIL prog_ypos_last: got %0d expected %0d", ypos_o, nl - 3);
    end
    vectors++;
    if (xpos_o !== 11'd719) begin
      miscompares++; $display("FAIL prog_xpos_last: got %0d expected 719", xpos_o);
    end
  endtask

  task automatic test_interlaced();
    int nl, pos;
    logic x_fid, x_il;
    nl = $urandom_range(5, 7);
    for (int f = 0; f < 4; f++) begin
      pos = (f % 2 == 0) ? 1 : 430;
      for (int l = 0; l < nl; l++)
        for (int i = 0; i < 858; i++) begin
          if (l == 0 && i == pos) vs_lvl = 1'b0;
          if (l == 3 && i == pos) vs_lvl = 1'b1;
          drive(ln_hs(i, 62), vs_lvl, (l >= 1) && ln_de(i, 122, 720));
          vectors++;
          if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL il_cycle f=%0d l=%0d i=%0d: got %h expected %h", f, l, i, obs_vec(), exp_vec());
          end
        end
`ifdef CAP_FID_DETECT_EN
      x_fid = (f % 2 == 1);
      x_il  = (f >= 1);
`else
      x_fid = 1'b0;
      x_il  = 1'b0;
`endif
      vectors++;
      if (FID_o !== x_fid) begin
        miscompares++; $display("FAIL il_fid f=%0d: got %b expected %b", f, FID_o, x_fid);
      end
      vectors++;
      if (interlaced_o !== x_il) begin
        miscompares++; $display("FAIL il_interlaced f=%0d: got %b expected %b", f, interlaced_o, x_il);
      end
    end
  endtask

  task automatic test_de_saturation();
    for (int i = 0; i < 2400; i++) begin
      drive(ln_hs(i, 62), vs_lvl, ln_de(i, 100, 2100));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL sat_cycle i=%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 2200) begin
        vectors++;
        if (xpos_o !== 11'd2047 || DE_o !== 1'b1) begin
          miscompares++; $display("FAIL sat_xpos_max: got x=%0d de=%b expected 2047 1", xpos_o, DE_o);
        end
      end
    end
    for (int i = 0; i < 858; i++) begin
      drive(ln_hs(i, 62), vs_lvl, ln_de(i, 122, 720));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL sat_next_cycle i=%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        vectors++;
        if (h_total_o !== 12'd2400) begin
          miscompares++; $display("FAIL sat_h_total: got %0d expected 2400", h_total_o);
        end
      end
      if (i == 123) begin
        vectors++;
        if (xpos_o !== 11'd0 || DE_o !== 1'b1) begin
          miscompares++; $display("FAIL sat_xpos_restart: got x=%0d de=%b expected 0 1", xpos_o, DE_o);
        end
      end
    end
  endtask

  task automatic test_coincident_fc();
    for (int f = 0; f < 4; f++)
      for (int l = 0; l < ((f == 3) ? 1 : 5); l++)
        for (int i = 0; i < 100; i++) begin
          if (l == 0 && i == 0) vs_lvl = 1'b0;
          if (l == 2 && i == 0) vs_lvl = 1'b1;
          drive(ln_hs(i, 10), vs_lvl, ln_de(i, 20, 60));
          vectors++;
          if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL fc_cycle f=%0d l=%0d i=%0d: got %h expected %h", f, l, i, obs_vec(), exp_vec());
          end
          if (f == 1 && i <= 1 && l <= 2) begin
            vectors++;
            if (frame_change_o !== ((l == 0 && i == 0) ? 1'b0 : (l == 2 && i == 1) ? 1'b0 : 1'b1)) begin
              miscompares++; $display("FAIL fc_pulse l=%0d i=%0d: got %b", l, i, frame_change_o);
            end
          end
          if (f >= 1 && l == 0 && i == 5) begin
            vectors++;
            if (v_total_o !== 11'd5) begin
              miscompares++; $display("FAIL fc_v_total f=%0d: got %0d expected 5", f, v_total_o);
            end
          end
        end
  endtask

  task automatic test_reset_midline();
    vs_lvl = 1'b1;
    for (int i = 0; i < 400; i++)
      drive(ln_hs(i, 62), vs_lvl, ln_de(i, 122, 720));
    #2;
    rst_n = 1'b0;
    {HSYNC_i, VSYNC_i, DE_i} = 3'b110;
    #1;
    vectors++;
    if ({HSYNC_o, VSYNC_o, DE_o} !== 3'b110) begin
      miscompares++; $display("FAIL mid_reset_syncs: got %b expected 110", {HSYNC_o, VSYNC_o, DE_o});
    end
    vectors++;
    if ({R_o, G_o, B_o, xpos_o, ypos_o} !== 46'd0) begin
      miscompares++; $display("FAIL mid_reset_data: got x=%0d y=%0d rgb=%h expected 0", xpos_o, ypos_o, {R_o, G_o, B_o});
    end
    vectors++;
    if ({h_total_o, v_total_o, frame_change_o, FID_o, interlaced_o} !== 26'd0) begin
      miscompares++; $display("FAIL mid_reset_status: got h=%0d v=%0d fc=%b expected 0", h_total_o, v_total_o, frame_change_o);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int l = 0; l < 5; l++)
      for (int i = 0; i < 858; i++) begin
        if (l == 3 && i == 0) vs_lvl = 1'b0;
        if (l == 4 && i == 0) vs_lvl = 1'b1;
        drive(ln_hs(i, 62), vs_lvl, ln_de(i, 122, 720));
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++; $display("FAIL mid_cycle l=%0d i=%0d: got %h expected %h", l, i, obs_vec(), exp_vec());
        end
        if (i == 5 && l <= 1) begin
          vectors++;
          if (h_total_o !== ((l == 0) ? 12'd0 : 12'd858)) begin
            miscompares++; $display("FAIL mid_h_total l=%0d: got %0d", l, h_total_o);
          end
        end
      end
    vectors++;
    if (v_total_o !== 11'd0) begin
      miscompares++; $display("FAIL mid_v_total: got %0d expected 0", v_total_o);
    end
  endtask

  initial begin
    {R_i, G_i, B_i} = 24'd0;
    {HSYNC_i, VSYNC_i, DE_i} = 3'b110;
    vs_lvl = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_progressive();
    test_interlaced();
    test_de_saturation();
    test_coincident_fc();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
